// File: rtl/stepper_motion_profile.sv
// Trapezoidal stepper motion profile generator.
// Accepts an absolute target with cruise velocity and acceleration, then on each
// qualifying step tick advances the phase through accel / cruise / decel ramps,
// snapping exactly onto the target. A pending abort ramps down to a stop instead.
module stepper_motion_profile #(
  parameter int PHASE_WIDTH = 32,
  parameter int VEL_WIDTH   = 24
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   enable,
  input  logic                   step_tick,
  input  logic [PHASE_WIDTH-1:0] cmd_target,
  input  logic [VEL_WIDTH-1:0]   cmd_vmax,
  input  logic [VEL_WIDTH-1:0]   cmd_acc,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic                   abort,
  output logic [PHASE_WIDTH-1:0] phase,
  output logic                   busy,
  output logic                   done,
  output logic                   aborted,
  output logic                   cmd_error
);

  typedef enum logic [1:0] {IDLE, ACCEL, CRUISE, DECEL} state_t;

  state_t                 state_q, state_d;
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic [PHASE_WIDTH-1:0] target_q, target_d;
  logic [PHASE_WIDTH-1:0] ramp_q, ramp_d;
  logic [VEL_WIDTH-1:0]   v_q, v_d;
  logic [VEL_WIDTH-1:0]   vmax_q, vmax_d;
  logic [VEL_WIDTH-1:0]   acc_q, acc_d;
  logic                   dir_neg_q, dir_neg_d;
  logic                   abort_q, abort_d;
  logic                   done_q, done_d;
  logic                   aborted_q, aborted_d;
  logic                   cmd_error_q, cmd_error_d;

  // Datapath terms shared by every moving-state tick.
  logic [PHASE_WIDTH-1:0] diff, rem, rem_post, step, phase_move, ramp_sat;
  logic [PHASE_WIDTH:0]   ramp_sum;
  logic [VEL_WIDTH:0]     v_inc;
  logic [VEL_WIDTH-1:0]   v_accel, v_apply, v_dec, v_floor;
  logic                   abort_now, snap, abort_end, tick;

  assign tick       = enable & step_tick;
  assign diff       = cmd_target - phase_q;
  assign rem        = dir_neg_q ? (phase_q - target_q) : (target_q - phase_q);
  // An abort arriving on a tick cycle takes effect on that same tick.
  assign abort_now  = abort_q | abort;
  assign v_inc      = {1'b0, v_q} + {1'b0, acc_q};
  assign v_accel    = (v_inc > {1'b0, vmax_q}) ? vmax_q : v_inc[VEL_WIDTH-1:0];
  assign v_apply    = (state_q == ACCEL && !abort_now) ? v_accel : v_q;
  assign step       = {{(PHASE_WIDTH-VEL_WIDTH){1'b0}}, v_apply};
  assign snap       = (rem <= step);
  assign phase_move = dir_neg_q ? (phase_q - step) : (phase_q + step);
  assign rem_post   = rem - step;
  assign ramp_sum   = {1'b0, ramp_q} + {1'b0, step};
  assign ramp_sat   = ramp_sum[PHASE_WIDTH] ? '1 : ramp_sum[PHASE_WIDTH-1:0];
  assign v_dec      = (v_q > acc_q) ? (v_q - acc_q) : '0;
  // Normal deceleration never drops below one acc step so the move always finishes.
  assign v_floor    = (v_dec > acc_q) ? v_dec : acc_q;
  assign abort_end  = (v_q <= acc_q);

  // Next-state: command accept in IDLE, abort latch and per-tick motion otherwise.
  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    target_d    = target_q;
    ramp_d      = ramp_q;
    v_d         = v_q;
    vmax_d      = vmax_q;
    acc_d       = acc_q;
    dir_neg_d   = dir_neg_q;
    abort_d     = abort_q;
    done_d      = 1'b0;
    aborted_d   = 1'b0;
    cmd_error_d = 1'b0;
    if (state_q == IDLE) begin
      if (cmd_valid) begin
        target_d  = cmd_target;
        vmax_d    = cmd_vmax;
        acc_d     = cmd_acc;
        v_d       = '0;
        ramp_d    = '0;
        dir_neg_d = diff[PHASE_WIDTH-1];
        abort_d   = 1'b0;
        if (cmd_vmax == '0 || cmd_acc == '0) begin
          cmd_error_d = 1'b1;
        end else if (diff == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = ACCEL;
        end
      end
    end else begin
      if (abort) abort_d = 1'b1;
      if (tick) begin
        if (snap) begin
          phase_d = target_q;
          v_d     = '0;
          abort_d = 1'b0;
          done_d  = 1'b1;
          state_d = IDLE;
        end else begin
          phase_d = phase_move;
          if (abort_now) begin
            state_d = DECEL;
            abort_d = 1'b1;
            if (abort_end) begin
              v_d       = '0;
              target_d  = phase_move;
              abort_d   = 1'b0;
              aborted_d = 1'b1;
              state_d   = IDLE;
            end else begin
              v_d = v_q - acc_q;
            end
          end else begin
            case (state_q)
              ACCEL: begin
                v_d    = v_accel;
                ramp_d = ramp_sat;
                if (v_accel == vmax_q) state_d = CRUISE;
                if (rem_post <= ramp_sat) state_d = DECEL;
              end
              CRUISE: begin
                if (rem_post <= ramp_q) state_d = DECEL;
              end
              DECEL: begin
                v_d = v_floor;
              end
              default: state_d = IDLE;
            endcase
          end
        end
      end
    end
  end

  // State and registered outputs, asynchronously cleared.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      phase_q     <= '0;
      target_q    <= '0;
      ramp_q      <= '0;
      v_q         <= '0;
      vmax_q      <= '0;
      acc_q       <= '0;
      dir_neg_q   <= 1'b0;
      abort_q     <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      target_q    <= target_d;
      ramp_q      <= ramp_d;
      v_q         <= v_d;
      vmax_q      <= vmax_d;
      acc_q       <= acc_d;
      dir_neg_q   <= dir_neg_d;
      abort_q     <= abort_d;
      done_q      <= done_d;
      aborted_q   <= aborted_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign phase     = phase_q;
  assign busy      = (state_q != IDLE);
  assign cmd_ready = (state_q == IDLE);
  assign done      = done_q;
  assign aborted   = aborted_q;
  assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_stepper_motion_profile.sv
// Bench for stepper_motion_profile: an integer-arithmetic model of the motion
// rules is checked against the DUT every cycle, and directed moves pin the
// model with hand-computed phase sequences.
module tb_stepper_motion_profile;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enable = 1'b1;
  logic        step_tick = 1'b0;
  logic [31:0] cmd_target = '0;
  logic [23:0] cmd_vmax = '0;
  logic [23:0] cmd_acc = '0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        abort = 1'b0;
  logic [31:0] phase;
  logic        busy, done, aborted, cmd_error;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  stepper_motion_profile #(.PHASE_WIDTH(32), .VEL_WIDTH(24)) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .step_tick(step_tick),
    .cmd_target(cmd_target), .cmd_vmax(cmd_vmax), .cmd_acc(cmd_acc),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .abort(abort),
    .phase(phase), .busy(busy), .done(done), .aborted(aborted),
    .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_phase, m_target;
  int          m_v, m_vmax, m_acc, m_stage; // stage 1 speeding up, 2 steady, 3 slowing
  longint      m_ramp;
  bit          m_neg, m_busy, m_pend, m_done, m_abd, m_err;

  task automatic model_reset();
    m_phase = '0; m_target = '0; m_v = 0; m_vmax = 0; m_acc = 0; m_stage = 0;
    m_ramp = 0; m_neg = 0; m_busy = 0; m_pend = 0; m_done = 0; m_abd = 0; m_err = 0;
  endtask

  task automatic model_step();
    logic [31:0] d, rem;
    int     vel;
    longint left;
    bit     ab;
    m_done = 0; m_abd = 0; m_err = 0;
    if (!m_busy) begin
      if (cmd_valid) begin
        m_target = cmd_target; m_vmax = int'(cmd_vmax); m_acc = int'(cmd_acc);
        m_v = 0; m_ramp = 0; m_pend = 0;
        d = cmd_target - m_phase;
        m_neg = d[31];
        if (cmd_vmax == 0 || cmd_acc == 0) m_err = 1;
        else if (d == 0) m_done = 1;
        else begin m_busy = 1; m_stage = 1; end
      end
    end else begin
      ab = m_pend || abort;
      if (abort) m_pend = 1;
      if (enable && step_tick) begin
        rem = m_neg ? (m_phase - m_target) : (m_target - m_phase);
        if (ab) vel = m_v;
        else if (m_stage == 1) vel = (m_v + m_acc > m_vmax) ? m_vmax : m_v + m_acc;
        else vel = m_v;
        if (longint'(rem) <= longint'(vel)) begin
          m_phase = m_target; m_v = 0; m_busy = 0; m_pend = 0; m_done = 1;
        end else begin
          m_phase = m_neg ? (m_phase - 32'(vel)) : (m_phase + 32'(vel));
          left = longint'(rem) - vel;
          if (ab) begin
            m_stage = 3;
            if (m_v - m_acc <= 0) begin
              m_v = 0; m_target = m_phase; m_busy = 0; m_pend = 0; m_abd = 1;
            end else m_v = m_v - m_acc;
          end else if (m_stage == 1) begin
            m_v = vel; m_ramp += vel;
            if (m_v == m_vmax) m_stage = 2;
            if (left <= m_ramp) m_stage = 3;
          end else if (m_stage == 2) begin
            if (left <= m_ramp) m_stage = 3;
          end else begin
            m_v = (m_v - m_acc > m_acc) ? m_v - m_acc : m_acc;
          end
        end
      end
    end
  endtask

  // Model advances on the same edges as the DUT, including async reset.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) model_reset();
    else model_step();
  end

  // Per-cycle comparison of every output against the model.
  always @(posedge clk) begin
    #1;
    chk("cyc_phase", phase, m_phase);
    chk("cyc_busy", busy, m_busy);
    chk("cyc_cmd_ready", cmd_ready, !m_busy);
    chk("cyc_done", done, m_done);
    chk("cyc_aborted", aborted, m_abd);
    chk("cyc_cmd_error", cmd_error, m_err);
  end

  // Issue a command and check the phase after each tick against exp_q.
  // fin: 0 = expect done at last tick, 1 = expect aborted, 2 = no end check.
  task automatic run_move(input string tag, input int tgt, input int vm, input int ac,
                          input int abort_at, input int fin);
    @(negedge clk);
    cmd_target = 32'(tgt); cmd_vmax = 24'(vm); cmd_acc = 24'(ac); cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 0; k < exp_q.size(); k++) begin
      abort = (k == abort_at);
      @(posedge clk); #1;
      chk($sformatf("%s_tick%0d_phase", tag, k + 1), phase, exp_q[k]);
      if (k == exp_q.size() - 1 && fin == 0) begin
        chk($sformatf("%s_done", tag), done, 1);
        chk($sformatf("%s_busy_low", tag), busy, 0);
      end
      if (k == exp_q.size() - 1 && fin == 1) begin
        chk($sformatf("%s_aborted", tag), aborted, 1);
        chk($sformatf("%s_no_done", tag), done, 0);
        chk($sformatf("%s_ready", tag), cmd_ready, 1);
      end
      @(negedge clk);
    end
    abort = 1'b0;
    $display("move %s target=%0d vmax=%0d acc=%0d ticks=%0d phase=%0d", tag, tgt, vm, ac,
             exp_q.size(), phase);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_phase", phase, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cmd_ready, 1);
    chk("rst_pulses", {done, aborted, cmd_error}, 0);
    reset_n = 1'b1;
    step_tick = 1'b1;

    exp_q = '{2, 6, 12, 20, 30, 40, 50, 60, 70, 80, 88, 94, 98, 100};
    run_move("up100", 100, 10, 2, -1, 0);
    exp_q = '{98, 94, 88, 80, 70, 60, 50, 40, 30, 20, 12, 6, 2, 0};
    run_move("down0", 0, 10, 2, -1, 0);
    exp_q = '{2, 6, 12, 18, 20};
    run_move("short20", 20, 10, 2, -1, 0);

    // Rejected command: acc = 0.
    @(negedge clk);
    cmd_target = 32'd50; cmd_vmax = 24'd10; cmd_acc = 24'd0; cmd_valid = 1'b1;
    @(posedge clk); #1;
    chk("err_acc0_pulse", cmd_error, 1);
    chk("err_acc0_busy", busy, 0);
    chk("err_acc0_phase", phase, 20);
    @(negedge clk);
    cmd_vmax = 24'd0; cmd_acc = 24'd2;
    @(posedge clk); #1;
    chk("err_vmax0_pulse", cmd_error, 1);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("err_pulse_end", cmd_error, 0);
    $display("cmd rejected acc=0 and vmax=0 phase=%0d", phase);

    // Command to current position: done only.
    @(negedge clk);
    cmd_target = 32'd20; cmd_vmax = 24'd10; cmd_acc = 24'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    chk("same_done", done, 1);
    chk("same_busy", busy, 0);
    chk("same_err", cmd_error, 0);
    @(negedge clk);
    cmd_valid = 1'b0;
    $display("cmd target==phase done=%0d", done);

    // Reset in mid-cruise.
    exp_q = '{22, 26, 32, 40, 50, 60, 70};
    run_move("cruise_rst", 120, 10, 2, -1, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_phase", phase, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_pulses", {done, aborted, cmd_error}, 0);
    @(negedge clk);
    reset_n = 1'b1;
    $display("reset mid-cruise phase=%0d busy=%0d", phase, busy);

    // Abort after sixth tick.
    exp_q = '{2, 6, 12, 20, 30, 40, 50, 58, 64, 68, 70};
    run_move("abort", 100, 10, 2, 6, 1);
    repeat (4) @(negedge clk);

    // Abort while idle is ignored.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    @(posedge clk); #1;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_pulse", aborted, 0);
    $display("abort in idle ignored phase=%0d", phase);

    // Move with enable toggling: dropped ticks leave state untouched.
    @(negedge clk);
    cmd_target = 32'd90; cmd_vmax = 24'd10; cmd_acc = 24'd2; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      enable = (c % 3 != 0);
      @(negedge clk);
    end
    enable = 1'b1;
    chk("gated_phase", phase, 90);
    chk("gated_busy", busy, 0);
    $display("gated move target=90 phase=%0d", phase);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/stepper_motion_profile.md
STEPPER_MOTION_PROFILE -- requirements
Module: stepper_motion_profile

Interface
REQ-001 Parameter PHASE_WIDTH, 32, width of position/phase output (Q-format fixed by consumer).
REQ-002 Parameter VEL_WIDTH, 24, width of unsigned velocity and acceleration operands, in phase units per tick.
REQ-003 Port reset_n  input  1  asynchronous active-low reset.
REQ-004 Port clk  input  1  single clock; all logic in this domain.
REQ-005 Port enable  input  1  when 0, ticks are ignored and all state holds.
REQ-006 Port step_tick  input  1  one-cycle motion-update strobe, driven by the PWM block's update output.
REQ-007 Port cmd_target  input  PHASE_WIDTH  absolute target position.
REQ-008 Port cmd_vmax  input  VEL_WIDTH  cruise velocity magnitude.
REQ-009 Port cmd_acc  input  VEL_WIDTH  acceleration magnitude per tick.
REQ-010 Port cmd_valid / cmd_ready  input / output  1  valid-ready command handshake.
REQ-011 Port abort  input  1  one-cycle request to ramp down to stop.
REQ-012 Port phase  output  PHASE_WIDTH  current position, registered.
REQ-013 Port busy  output  1  state is not IDLE.
REQ-014 Port done / aborted / cmd_error  output  1  one-cycle completion / abort-complete / rejected-command pulses.

Function
REQ-015 States IDLE, ACCEL, CRUISE, DECEL; state, velocity v, ramp_dist and phase change only on cycles with enable=1 and step_tick=1, except command accept and abort latch.
REQ-016 cmd_ready = 1 only in IDLE; accept on cmd_valid & cmd_ready; latch target, vmax, acc; v=0, ramp_dist=0; dir = sign(target - phase) as a PHASE_WIDTH signed difference.
REQ-017 Accepted command with vmax=0 or acc=0: cmd_error pulse next cycle, stay IDLE, no motion.
REQ-018 Accepted command with target == phase: done pulse next cycle, stay IDLE.
REQ-019 Otherwise go to ACCEL next cycle; first motion on the first qualifying tick after accept.
REQ-020 rem = |target - phase| evaluated before the tick's move; |target - phase| < 2^(PHASE_WIDTH-1) is a caller obligation; phase wraps modulo 2^PHASE_WIDTH.
REQ-021 ACCEL tick: v' = min(v + acc, vmax); ramp_dist += v' (saturating); phase += dir*v'; if v' == vmax go CRUISE.
REQ-022 CRUISE tick: phase += dir*v.
REQ-023 In ACCEL/CRUISE, if post-move remaining <= ramp_dist, go DECEL (overrides ACCEL->CRUISE).
REQ-024 DECEL tick: phase += dir*v, then v = max(v - acc, acc) (creep floor).
REQ-025 Any moving state: if rem <= velocity to be applied this tick, phase = target, v = 0, IDLE, done pulse the following cycle.
REQ-026 phase output updates one clk after the qualifying tick.
REQ-027 abort while busy latches a pending abort; on the next qualifying tick go/stay DECEL in abort mode: phase += dir*v, v -= acc; when v - acc <= 0, set v = 0, target = phase, go IDLE, pulse aborted (not done).
REQ-028 abort in IDLE is ignored; abort on the same cycle as command accept is ignored.
REQ-029 Snap-to-target (REQ-025) takes priority over abort completion on the same tick.
REQ-030 Tick while enable=0 is lost, not queued.

Reset
REQ-031 reset_n=0 asynchronously forces IDLE, phase=0, v=0, ramp_dist=0, target=0, pending abort cleared, busy=0, done=aborted=cmd_error=0, cmd_ready=1 after release.
REQ-032 Reset mid-motion discards the command; no done or aborted pulse is produced.

Verification
REQ-033 phase=0, cmd target=100, vmax=10, acc=2, tick every cycle -> phase 2,6,12,20,30,40,50,60,70,80,88,94,98,100; done on 14th tick; busy falls with done.
REQ-034 phase=0, target=20, vmax=10, acc=2 -> phase 2,6,12 (DECEL entry, v=6), 18, 20 snapped; done once.
REQ-035 phase=100, target=0, vmax=10, acc=2 -> mirror of REQ-033 descending to 0; no wrap.
REQ-036 REQ-033 setup, abort after 6th tick (phase=40, v=10) -> phase 50,58,64,68,70; aborted pulse; no done; cmd_ready=1.
REQ-037 cmd with acc=0 -> cmd_error pulse, busy stays 0; cmd with target==phase -> done pulse only; reset_n low mid-CRUISE -> phase=0, busy=0 immediately, no pulses.
